// File: rtl/in_unit_buf_if.sv
// Handshake and instruction-field interfaces used by in_unit_buf.
// req_if carries a valid/ready pair; inst_if carries the issued opcode bits.

interface req_if;
  logic valid;
  logic ready;

  // Side that raises a request and waits for acceptance.
  modport initiator (output valid, input ready);
  // Side that accepts a request.
  modport target    (input valid, output ready);
endinterface

interface inst_if;
  // op[0]: 0 = GPR destination, 1 = FPR destination; op[1]: 1 = byte read.
  logic [1:0] op;

  modport sink   (input op);
  modport source (output op);
endinterface

// File: rtl/in_unit_buf.sv
// Buffered input-instruction unit: UART bytes enter a DEPTH-byte FIFO and `in`
// instructions pop one byte or one packed word onto the GPR/FPR CDB. Build macro IN_BYTE_READ_EN enables byte reads.

module in_unit_buf #(
  parameter int DEPTH      = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  inst_if.sink                     inst,
  req_if.target                    issue_req,
  req_if.initiator                 gpr_cdb_req,
  req_if.initiator                 fpr_cdb_req,
  output logic [31:0]              result,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  input  logic                     speculating,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next, need, pop_n;
  logic          byte_rd, avail, push, fire, dest_ok;
  logic [7:0]    word_b [4];
  logic [31:0]   word;

`ifdef IN_BYTE_READ_EN
  assign byte_rd = inst.op[1];
`else
  // Every read is a word read; op[1] is deliberately ignored.
  logic unused_op1;
  assign unused_op1 = inst.op[1];
  assign byte_rd    = 1'b0;
`endif

  assign need     = byte_rd ? CW'(1) : CW'(4);
  assign avail    = (count >= need);
  assign dest_ok  = issue_req.valid && avail && !speculating;

  assign gpr_cdb_req.valid = dest_ok && !inst.op[0];
  assign fpr_cdb_req.valid = dest_ok &&  inst.op[0];

  assign fire = (gpr_cdb_req.valid && gpr_cdb_req.ready) ||
                (fpr_cdb_req.valid && fpr_cdb_req.ready);
  assign issue_req.ready = fire;

  // rx_ready looks only at count, so a full FIFO refuses a byte even while popping.
  assign rx_ready   = (count < CW'(DEPTH));
  assign push       = rx_valid && rx_ready;
  assign fifo_count = count;

  assign pop_n      = fire ? need : '0;
  assign count_next = count + CW'(push) - pop_n;

  // NOTE: every variable driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      word_b[i] = mem[head + PW'(i)];
    end
    word = BIG_ENDIAN ? {word_b[0], word_b[1], word_b[2], word_b[3]}
                      : {word_b[3], word_b[2], word_b[1], word_b[0]};
  end

`ifdef IN_BYTE_READ_EN
  assign result = byte_rd ? {24'h0, word_b[0]} : word;
`else
  assign result = word;
`endif

  // NOTE: storage carries no reset; only the pointers and count define what
  // is valid, so clearing the array would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= rx_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (fire) begin
        head <= head + need[PW-1:0];
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_in_unit_buf.sv
// Self-checking bench for in_unit_buf: a byte-level model queue predicts every
// read result, expected CDB transactions are queued and compared when the DUT fires.

module tb_in_unit_buf;

  localparam int DEPTH      = 16;
  localparam bit BIG_ENDIAN = 1'b1;
  localparam int CW         = $clog2(DEPTH) + 1;

`ifdef IN_BYTE_READ_EN
  localparam bit BYTE_MODE = 1'b1;
`else
  localparam bit BYTE_MODE = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    bit          fpr;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [31:0]   result;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          speculating;
  logic [CW-1:0] fifo_count;

  inst_if inst_bus ();
  req_if  issue_bus ();
  req_if  gpr_bus ();
  req_if  fpr_bus ();

  in_unit_buf #(.DEPTH(DEPTH), .BIG_ENDIAN(BIG_ENDIAN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inst        (inst_bus),
    .issue_req   (issue_bus),
    .gpr_cdb_req (gpr_bus),
    .fpr_cdb_req (fpr_bus),
    .result      (result),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .speculating (speculating),
    .fifo_count  (fifo_count)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mq[$];
  exp_t       sb[$];
  int         head_model = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_word();
    return BIG_ENDIAN ? {mq[0], mq[1], mq[2], mq[3]} : {mq[3], mq[2], mq[1], mq[0]};
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    mq.push_back(b);
    #1 rx_valid = 1'b0;
  endtask

  // Queue the model's prediction, pop the model, then issue and wait for the CDB.
  task automatic issue_read(input bit fpr, input bit byte_rd, input string name);
    exp_t e;
    exp_t got;
    int   n;
    bit   fired;
    n      = byte_rd ? 1 : 4;
    e.fpr  = fpr;
    e.data = byte_rd ? {24'h0, mq[0]} : model_word();
    sb.push_back(e);
    repeat (n) void'(mq.pop_front());
    head_model += n;

    @(negedge clk);
    inst_bus.op     = {byte_rd, fpr};
    issue_bus.valid = 1'b1;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      #1;
      if (gpr_bus.valid || fpr_bus.valid) begin
        fired = 1'b1;
        got   = sb.pop_front();
        checks++;
        if (result !== got.data || fpr_bus.valid !== got.fpr ||
            gpr_bus.valid !== !got.fpr || issue_bus.ready !== 1'b1) begin
          errors++;
          $display("FAIL %s: result=%h gpr=%b fpr=%b ready=%b, want result=%h fpr=%b ready=1",
                   name, result, gpr_bus.valid, fpr_bus.valid, issue_bus.ready, got.data, got.fpr);
        end
      end
      @(negedge clk);
    end
    issue_bus.valid = 1'b0;
    if (!fired) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no CDB valid within 20 cycles", name);
      sb.delete();
    end
    #1;
    checks++;
    if (fifo_count !== CW'(mq.size())) begin
      errors++;
      $display("FAIL %s_count: fifo_count=%0d want %0d", name, fifo_count, mq.size());
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    rx_valid        = 1'b0;
    rx_data         = '0;
    speculating     = 1'b0;
    inst_bus.op     = 2'b00;
    issue_bus.valid = 1'b1;
    gpr_bus.ready   = 1'b1;
    fpr_bus.ready   = 1'b1;
    #12;
    checks++;
    if (rx_ready !== 1'b1 || fifo_count !== '0 || gpr_bus.valid !== 1'b0 ||
        fpr_bus.valid !== 1'b0 || issue_bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: rx_ready=%b count=%0d gpr=%b fpr=%b ready=%b want 1 0 0 0 0",
               rx_ready, fifo_count, gpr_bus.valid, fpr_bus.valid, issue_bus.ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue_bus.valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b1 || fifo_count !== '0 || gpr_bus.valid !== 1'b0 || fpr_bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rx_ready=%b count=%0d gpr=%b fpr=%b", rx_ready, fifo_count,
               gpr_bus.valid, fpr_bus.valid);
    end
  endtask

  task automatic test_word_read();
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    push_byte(8'h78);
    checks++;
    if (fifo_count !== CW'(4)) begin
      errors++;
      $display("FAIL word_fill: fifo_count=%0d want 4", fifo_count);
    end
    issue_read(1'b0, 1'b0, "word_gpr");
  endtask

  task automatic test_stall();
    push_byte(8'hAB);
    @(negedge clk);
    inst_bus.op     = 2'b00;
    issue_bus.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (gpr_bus.valid !== 1'b0 || fpr_bus.valid !== 1'b0 || fifo_count !== CW'(1)) begin
        errors++;
        $display("FAIL stall_cycle%0d: gpr=%b fpr=%b count=%0d want 0 0 1", i, gpr_bus.valid,
                 fpr_bus.valid, fifo_count);
      end
      @(negedge clk);
    end
    issue_bus.valid = 1'b0;
    push_byte(8'hCD);
    push_byte(8'hEF);
    push_byte(8'h01);
    issue_read(1'b0, 1'b0, "stall_release");
  endtask

  task automatic test_byte_read();
    push_byte(8'h9C);
    issue_read(1'b1, 1'b1, "byte_fpr");
  endtask

  task automatic test_full();
    exp_t e;
    exp_t got;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h40 + 8'(i));
    checks++;
    if (rx_ready !== 1'b0 || fifo_count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full_state: rx_ready=%b count=%0d want 0 %0d", rx_ready, fifo_count, DEPTH);
    end
    e.fpr  = 1'b0;
    e.data = model_word();
    sb.push_back(e);
    repeat (4) void'(mq.pop_front());
    head_model += 4;
    @(negedge clk);
    rx_valid        = 1'b1;
    rx_data         = 8'hEE;
    inst_bus.op     = 2'b00;
    issue_bus.valid = 1'b1;
    #1;
    got = sb.pop_front();
    checks++;
    if (gpr_bus.valid !== 1'b1 || result !== got.data || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop: gpr=%b result=%h rx_ready=%b want 1 %h 0", gpr_bus.valid, result,
               rx_ready, got.data);
    end
    @(negedge clk);
    rx_valid        = 1'b0;
    issue_bus.valid = 1'b0;
    #1;
    checks++;
    if (fifo_count !== CW'(12) || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after: count=%0d rx_ready=%b want 12 1", fifo_count, rx_ready);
    end
    for (int i = 0; i < 3; i++) issue_read(1'b0, 1'b0, "full_drain");
  endtask

  task automatic test_speculate();
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    speculating = 1'b1;
    @(negedge clk);
    inst_bus.op     = 2'b01;
    issue_bus.valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (gpr_bus.valid !== 1'b0 || fpr_bus.valid !== 1'b0 || issue_bus.ready !== 1'b0 ||
          fifo_count !== CW'(8)) begin
        errors++;
        $display("FAIL spec_cycle%0d: gpr=%b fpr=%b ready=%b count=%0d want 0 0 0 8", i,
                 gpr_bus.valid, fpr_bus.valid, issue_bus.ready, fifo_count);
      end
      @(negedge clk);
    end
    issue_bus.valid = 1'b0;
    speculating     = 1'b0;
    issue_read(1'b1, 1'b0, "spec_release");
    issue_read(1'b0, 1'b0, "spec_drain");
  endtask

  task automatic test_wrap();
    int target;
    target = BYTE_MODE ? DEPTH - 2 : DEPTH - 4;
    for (int guard = 0; guard < 32 && (head_model % DEPTH) != target; guard++) begin
      if (BYTE_MODE && ((target - (head_model % DEPTH) + DEPTH) % 4) != 0) begin
        push_byte(8'h5A);
        issue_read(1'b0, 1'b1, "wrap_step_byte");
      end else begin
        for (int i = 0; i < 4; i++) push_byte(8'h60 + 8'(i));
        issue_read(1'b0, 1'b0, "wrap_step_word");
      end
    end
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
    issue_read(1'b0, 1'b0, "wrap_word0");
    issue_read(1'b1, 1'b0, "wrap_word1");
  endtask

  task automatic test_reset_mid();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    @(negedge clk);
    inst_bus.op     = 2'b00;
    issue_bus.valid = 1'b1;
    rx_valid        = 1'b1;
    rx_data         = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_count !== '0 || rx_ready !== 1'b1 || gpr_bus.valid !== 1'b0 ||
        fpr_bus.valid !== 1'b0 || issue_bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: count=%0d rx_ready=%b gpr=%b fpr=%b ready=%b want 0 1 0 0 0",
               fifo_count, rx_ready, gpr_bus.valid, fpr_bus.valid, issue_bus.ready);
    end
    @(negedge clk);
    issue_bus.valid = 1'b0;
    rx_valid        = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    sb.delete();
    head_model = 0;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    issue_read(1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_stall();
    if (BYTE_MODE) test_byte_read();
    test_full();
    test_speculate();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
